down_counter_load: RTL
======================

Name: down_counter_load

Overview:
- Loadable down counter with terminal-count detection; the count-down counterpart of the team's 4-bit up counter with load.
- Used as a programmable delay/timer: software or an FSM loads a start value, the block decrements on enable, and it flags expiry.
- Sits beside the up counter in the counter library.
- Drives timeout/strobe logic in downstream blocks.

Parameters:
- WIDTH, 4, counter and load-data width in bits (legal range 2..16).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- load  input  1  synchronous load strobe; d is captured into q on the next rising edge.
- en  input  1  count enable; decrements q by 1 per cycle while running.
- d  input  WIDTH  load value.
- q  output  WIDTH  current count, registered.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse, registered, on the cycle q reaches 0 by counting.
- expired  output  1  sticky flag, set with done and cleared by load or reset.

Behaviour:
- Reset (async, rst_n=0):
  - q=0, busy=0, done=0, expired=0, state=IDLE.
  - Takes effect immediately, mid-count included.
  - The first edge after rst_n deasserts is a normal edge.
- States are IDLE, RUN and EXPIRED.
- Load:
  - Priority order on each edge: load > en > hold.
  - load=1 from any state: q<=d, done<=0, expired<=0.
  - Next state is RUN if d!=0, else IDLE; there is no done pulse for d==0.
  - In RUN, load restarts the count; en is ignored that cycle.
- Counting:
  - RUN with en=1 and q>1: q<=q-1.
  - RUN with en=1 and q==1: q<=0, done<=1 for exactly one cycle, expired<=1, state<=EXPIRED.
  - RUN with en=0: q, state and flags hold; done stays 0.
- IDLE and EXPIRED:
  - q holds (0 in EXPIRED) and en is ignored.
  - No wrap-around ever: the counter never goes below 0 to all-ones.
- Simultaneous events: load on the same edge as the q==1 expiry wins, with no done pulse and expired staying 0.
- Latency:
  - Load value is visible on q one cycle after the load edge.
  - From a load of N with en held high, done asserts N edges after the load edge.
- busy = (state==RUN), registered with state.
- Full-scale load (all ones) counts 2^WIDTH-1 enabled cycles.

Optional Feature:
- Macro: DOWN_COUNTER_AUTO_RELOAD_EN.
- Defined:
  - A WIDTH-bit reload register captures d on every load.
  - On the q==1 & en expiry edge: q<=reload, done pulses for one cycle, expired<=1, and the state stays RUN.
  - The result is a periodic strobe every N enabled cycles.
  - EXPIRED is unreachable. busy stays 1. expired is still sticky until the next load.
- Not defined: one-shot behaviour as above, and no reload register is synthesised.

Decomposition:
- Shared package (counter_pkg):
  - State typedef: IDLE=2'd0, RUN=2'd1, EXPIRED=2'd2.
  - Default WIDTH constant.
- No sub-module: a single always block for state and count plus a flag register.
- The reload register sits inside the macro guard.

Test Plan:
- Reset check: hold rst_n=0 for 3 cycles, then pulse rst_n low mid-count at q=5 → q=0, busy=0, done=0 and expired=0, asynchronously, before the next edge.
- One-shot: load d=4'b1001, then en=1 continuously → q steps 9,8,...,1,0. done is high for exactly one cycle, 9 edges after the load edge. expired stays 1, busy drops, and q holds at 0 for 20 further cycles.
- Enable gating: load d=5, then toggle en 1,0,1,0 → q decrements only on en=1 edges. done appears after 5 enabled edges, not 5 clock edges.
- Load collision: load d=3 and count to q=1, then assert load d=7 on the expiry edge → q=7, done=0, expired=0, busy=1.
- Zero load: load d=0 with en=1 → state IDLE, q=0, no done pulse, busy=0.
- Auto-reload (macro defined): load d=3, en=1 → done pulses every 3 cycles, q sequence 3,2,1,3,2,1..., busy held at 1.

Source files
------------

// File: rtl/counter_pkg.sv
// Shared definitions for the counter library: FSM state encoding and the
// default counter width used by down_counter_load.
package counter_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        RUN     = 2'd1,
        EXPIRED = 2'd2
    } state_e;

endpackage

// File: rtl/down_counter_load.sv
// Loadable down counter with terminal-count detection, used as a programmable
// delay/timer. A load of a non-zero value starts a count-down. Each enabled
// cycle decrements q. When q reaches 0 by counting, done pulses for one cycle
// and expired is set sticky until the next load or reset.
//
// Optional build macro DOWN_COUNTER_AUTO_RELOAD_EN: on expiry the counter
// reloads the last loaded value and keeps running. This gives a periodic
// strobe every N enabled cycles.
module down_counter_load
    import counter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             busy,
    output logic             done,
    output logic             expired
);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] count_q, count_d;
    logic             done_q, done_d;
    logic             expired_q, expired_d;

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    logic [WIDTH-1:0] reload_q;
`endif

    // Next-state decode with priority load > en > hold; q never wraps below 0
    always_comb begin
        state_d   = state_q;
        count_d   = count_q;
        done_d    = 1'b0;
        expired_d = expired_q;
        if (load) begin
            count_d   = d;
            expired_d = 1'b0;
            state_d   = (d != '0) ? RUN : IDLE;
        end else if ((state_q == RUN) && en) begin
            if (count_q == WIDTH'(1)) begin
`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
                count_d = reload_q;
                state_d = RUN;
`else
                count_d = '0;
                state_d = EXPIRED;
`endif
                done_d    = 1'b1;
                expired_d = 1'b1;
            end else begin
                count_d = count_q - WIDTH'(1);
            end
        end
    end

    // State and count register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
        end
    end

    // Flag register: done is a one-cycle pulse, expired is sticky
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_q    <= 1'b0;
            expired_q <= 1'b0;
        end else begin
            done_q    <= done_d;
            expired_q <= expired_d;
        end
    end

`ifdef DOWN_COUNTER_AUTO_RELOAD_EN
    // Reload register remembers the most recent load value for periodic restart
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reload_q <= '0;
        end else if (load) begin
            reload_q <= d;
        end
    end
`endif

    assign q       = count_q;
    assign busy    = (state_q == RUN);
    assign done    = done_q;
    assign expired = expired_q;

endmodule
